// File: rtl/dac_spi_pkg.sv
// ============================================================================
// Module : dac_spi_pkg
// Brief  : Shared types and constants for the DDFS-to-SPI-DAC serialiser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    localparam int         c_frame_w          = 16;
    localparam logic [3:0] c_cmd_write_update = 4'b0011;
    localparam logic [3:0] c_cmd_power_down   = 4'b0100;

endpackage

`default_nettype wire

// File: rtl/dac_spi_tx_if.sv
// ============================================================================
// Module : dac_spi_tx_if
// Brief  : Sample handshake plus SPI pins between the DDFS and the DAC serialiser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dac_spi_tx_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              frame_done;
    logic              sclk;
    logic              mosi;
    logic              cs_n;

    modport master (
        output sample_in, sample_valid,
        input  sample_ready, busy, frame_done, sclk, mosi, cs_n
    );

    modport slave (
        input  sample_in, sample_valid,
        output sample_ready, busy, frame_done, sclk, mosi, cs_n
    );
endinterface

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// ============================================================================
// Module : spi_tick_gen
// Brief  : Half-period down-counter; o_tick marks the last clk of each sclk half.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_tick_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    generate
        if (HALF_DIV == 1) begin : g_div1
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_tick   = i_en;
        end else begin : g_divn
            localparam int              c_cw     = $clog2(HALF_DIV);
            localparam logic [c_cw-1:0] c_reload = c_cw'(HALF_DIV - 1);

            logic [c_cw-1:0] r_cnt;

            // Held at the reload value while disabled so the first enabled
            // cycle starts a full half-period.
            always_ff @(posedge clk) begin
                if (rst || !i_en) begin
                    r_cnt <= c_reload;
                end else if (r_cnt == '0) begin
                    r_cnt <= c_reload;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign o_tick = i_en && (r_cnt == '0);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// Module : dac_spi_tx
// Brief  : Serialises DDFS samples to an SPI DAC as {CMD, sample}, mode 0, MSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int               DATA_W    = 12,
    parameter int               CMD_W     = 4,
    parameter logic [CMD_W-1:0] CMD       = c_cmd_write_update,
    parameter int               HALF_DIV  = 2,
    parameter int               CS_GAP    = 2,
    parameter bit               SIGNED_IN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);

    localparam int c_fw = CMD_W + DATA_W;
    localparam int c_bw = $clog2(c_fw + 1);
    localparam int c_gw = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [c_bw-1:0]   c_last_fall = c_bw'(c_fw - 1);
    localparam logic [c_gw-1:0]   c_gap_load  = c_gw'(CS_GAP - 1);
    localparam logic [DATA_W-1:0] c_sign_flip = SIGNED_IN ? {1'b1, {(DATA_W-1){1'b0}}}
                                                          : {DATA_W{1'b0}};

    spi_state_t      r_state;
    logic [c_fw-1:0] r_shreg;
    logic [c_bw-1:0] r_bit_cnt;
    logic [c_gw-1:0] r_gap_cnt;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_sclk;
    logic            r_cs_n;

    logic            w_tick;
    logic            w_tick_en;
    logic            w_accept;
    logic [c_fw-1:0] w_frame;

    assign w_tick_en = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_accept  = (r_state == IDLE) && r_ready && bus.sample_valid;
    // Flipping the MSB turns two's complement into the DAC's offset binary.
    assign w_frame   = {CMD, bus.sample_in ^ c_sign_flip};

    spi_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_shreg   <= w_frame;
                        r_bit_cnt <= '0;
                        r_cs_n    <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            // The last bit stays on mosi through HOLD.
                            if (r_bit_cnt == c_last_fall) begin
                                r_state <= HOLD;
                            end else begin
                                r_shreg <= {r_shreg[c_fw-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_cs_n    <= 1'b1;
                        r_shreg   <= '0;
                        r_done    <= 1'b1;
                        r_gap_cnt <= c_gap_load;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sample_ready = r_ready;
    assign bus.busy         = r_busy;
    assign bus.frame_done   = r_done;
    assign bus.sclk         = r_sclk;
    assign bus.mosi         = r_shreg[c_fw-1];
    assign bus.cs_n         = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// ============================================================================
// Module : tb_dac_spi_tx
// Brief  : Three serialiser configurations checked cycle by cycle against a waveform model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst_v [3];
    logic [11:0] s_in  [3];
    logic        v_in  [3];
    logic [5:0]  obs   [3];

    int          m_st     [3];
    int          m_d      [3];
    logic [15:0] m_fr     [3];
    logic [15:0] cap      [3];
    logic [15:0] last_cap [3];
    int          ncap     [3];
    logic        psclk    [3];
    int          nacc     [3];
    int          goal     [3];
    bit          ddfs     [3];
    int          rst_at   [3];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dac_spi_tx_if #(.DATA_W(12)) if0 ();
    dac_spi_tx_if #(.DATA_W(12)) if1 ();
    dac_spi_tx_if #(.DATA_W(12)) if2 ();

    assign if0.sample_in = s_in[0];  assign if0.sample_valid = v_in[0];
    assign if1.sample_in = s_in[1];  assign if1.sample_valid = v_in[1];
    assign if2.sample_in = s_in[2];  assign if2.sample_valid = v_in[2];

    assign obs[0] = {if0.cs_n, if0.sclk, if0.mosi, if0.frame_done, if0.busy, if0.sample_ready};
    assign obs[1] = {if1.cs_n, if1.sclk, if1.mosi, if1.frame_done, if1.busy, if1.sample_ready};
    assign obs[2] = {if2.cs_n, if2.sclk, if2.mosi, if2.frame_done, if2.busy, if2.sample_ready};

    dac_spi_tx #(.HALF_DIV(2), .CS_GAP(2), .SIGNED_IN(1'b0)) u_dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0));
    dac_spi_tx #(.HALF_DIV(2), .CS_GAP(2), .SIGNED_IN(1'b1)) u_dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
    dac_spi_tx #(.HALF_DIV(1), .CS_GAP(1), .SIGNED_IN(1'b0)) u_dut2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

    function automatic int hd(int u);
        return (u == 2) ? 1 : 2;
    endfunction

    function automatic int gp(int u);
        return (u == 2) ? 1 : 2;
    endfunction

    function automatic bit sg(int u);
        return (u == 1);
    endfunction

    // Expected pins {cs_n, sclk, mosi, frame_done, busy, ready}; d counts cycles since accept.
    function automatic logic [5:0] wave(int st, int d, int h, logic [15:0] fr);
        logic sc;
        int   idx;
        if (st == 0) return 6'b100000;
        if (st == 1) return 6'b100001;
        if (d < 33 * h) begin
            sc  = (d >= h && d < 32 * h) ? ((d / h) % 2 == 1) : 1'b0;
            idx = d / (2 * h);
            if (idx > 15) idx = 15;
            return {1'b0, sc, fr[15 - idx], 1'b0, 1'b1, 1'b0};
        end
        if (d == 33 * h) return 6'b100110;
        return 6'b100010;
    endfunction

    task automatic chk(input string tag, input int u, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s unit%0d cyc%0d: observed %h expected %h", tag, u, cyc, got, exp);
        end
    endtask

    task automatic run(input int ncyc);
        logic        acc [3];
        logic [15:0] fr  [3];
        logic [5:0]  e;
        for (int i = 0; i < ncyc; i++) begin
            for (int u = 0; u < 3; u++) begin
                if (ddfs[u]) s_in[u] = s_in[u] + 12'd3;
                else if (nacc[u] >= goal[u]) s_in[u] = 12'($urandom);
                v_in[u]  = (nacc[u] < goal[u]);
                rst_v[u] = (rst_at[u] >= 0 && m_st[u] == 2 && m_d[u] == rst_at[u]);
                if (rst_v[u]) rst_at[u] = -1;
                acc[u] = v_in[u] && (m_st[u] == 1) && !rst_v[u];
                fr[u]  = {4'b0011, s_in[u] ^ (sg(u) ? 12'h800 : 12'h000)};
            end
            @(posedge clk);
            for (int u = 0; u < 3; u++) begin
                if (rst_v[u]) begin
                    m_st[u] = 0;
                end else if (m_st[u] == 0) begin
                    m_st[u] = 1;
                end else if (m_st[u] == 1) begin
                    if (acc[u]) begin
                        m_st[u] = 2;  m_d[u] = 0;  m_fr[u] = fr[u];
                        nacc[u]++;    cap[u] = '0; ncap[u] = 0;
                    end
                end else begin
                    m_d[u]++;
                    if (m_d[u] == 33 * hd(u) + gp(u)) m_st[u] = 1;
                end
            end
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                e = wave(m_st[u], m_d[u], hd(u), m_fr[u]);
                chk("pins", u, {10'd0, obs[u]}, {10'd0, e});
                if (!obs[u][5] && obs[u][4] && !psclk[u]) begin
                    cap[u] = {cap[u][14:0], obs[u][3]};
                    ncap[u]++;
                end
                psclk[u] = obs[u][4];
                if (m_st[u] == 2 && m_d[u] == 33 * hd(u)) begin
                    chk("frame", u, cap[u], m_fr[u]);
                    chk("rises", u, 16'(ncap[u]), 16'd16);
                    last_cap[u] = cap[u];
                end
            end
        end
        for (int u = 0; u < 3; u++) chk("accepts", u, 16'(nacc[u]), 16'(goal[u]));
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst_v[u] = 1'b1;  v_in[u] = 1'b0;  s_in[u] = '0;
            m_st[u] = 0;  m_d[u] = 0;  m_fr[u] = '0;  cap[u] = '0;  last_cap[u] = '0;
            ncap[u] = 0;  psclk[u] = 1'b0;  nacc[u] = 0;  goal[u] = 0;
            ddfs[u] = 1'b0;  rst_at[u] = -1;
        end

        // Reset held for five edges: idle pins, ready low.
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            for (int u = 0; u < 3; u++) chk("reset", u, {10'd0, obs[u]}, 16'h0020);
        end
        run(3);

        // One frame on each configuration.
        s_in[0] = 12'hA5C;  goal[0] = 1;
        s_in[1] = 12'h800;  goal[1] = 1;
        s_in[2] = 12'hFFF;  goal[2] = 1;
        run(80);
        chk("frame_a5c", 0, last_cap[0], 16'h3A5C);
        chk("signed_800", 1, last_cap[1], 16'h3000);
        chk("div1_fff", 2, last_cap[2], 16'h3FFF);

        s_in[1] = 12'h7FF;  goal[1] = 2;
        run(75);
        chk("signed_7ff", 1, last_cap[1], 16'h3FFF);

        // Valid held high with a ramping sample; random frames on the fast unit.
        s_in[0] = 12'($urandom);
        ddfs[0] = 1'b1;  goal[0] = 5;
        goal[2] = 4;
        goal[1] = 3;
        run(290);
        ddfs[0] = 1'b0;

        // Reset during cycle T+20 of a frame, then a clean frame afterwards.
        s_in[0] = 12'($urandom);
        goal[0] = 6;  rst_at[0] = 19;
        run(40);
        chk("rst_abort_idle", 0, {10'd0, obs[0]}, 16'h0021);
        s_in[0] = 12'($urandom);
        goal[0] = 7;
        run(75);
        chk("post_rst_frame", 0, last_cap[0], m_fr[0]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
